// File: rtl/exe_stage.sv
// Execute stage: latches the issue bundle, computes the ALU result in one cycle,
// runs mul.w on a 32-step shift-add multiplier, issues data-RAM requests and drives the bypass bus.
module exe_stage #(
    parameter int MUL_STEPS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ID_to_EXE_valid,
    input  logic [150:0] ID_to_EXE_bus,
    output logic         EXE_allow_in,
    input  logic         MEM_allow_in,
    output logic         EXE_to_MEM_valid,
    output logic [70:0]  EXE_to_MEM_bus,
    output logic [38:0]  EXE_BY_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    localparam int CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    logic         exe_valid_r;
    logic [150:0] bundle_r;
    mul_state_e   state_r;
    mul_state_e   state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]  acc_r;
    logic [31:0]  mcand_r;
    logic [31:0]  mplier_r;

    logic         rf_w_en_s;
    logic         rf_w_data_sel_s;
    logic         unused_ram_wd_s;
    logic         ram_we_s;
    logic         ram_en_s;
    logic [31:0]  ram_wdata_s;
    logic [4:0]   w_addr_s;
    logic [12:0]  alu_op_s;
    logic [31:0]  src2_s;
    logic [31:0]  src1_s;
    logic [31:0]  pc_s;

    assign rf_w_en_s       = bundle_r[150];
    assign rf_w_data_sel_s = bundle_r[149];
    assign unused_ram_wd_s = bundle_r[148];
    assign ram_we_s        = bundle_r[147];
    assign ram_en_s        = bundle_r[146];
    assign ram_wdata_s     = bundle_r[145:114];
    assign w_addr_s        = bundle_r[113:109];
    assign alu_op_s        = bundle_r[108:96];
    assign src2_s          = bundle_r[95:64];
    assign src1_s          = bundle_r[63:32];
    assign pc_s            = bundle_r[31:0];

    logic op_mul_s;
    logic ready_go_s;
    logic handoff_s;
    logic mul_start_s;
    logic data_valid_s;

    assign op_mul_s     = alu_op_s[12];
    assign ready_go_s   = ~op_mul_s | (state_r == DONE);
    assign EXE_allow_in = ~exe_valid_r | (ready_go_s & MEM_allow_in);
    assign handoff_s    = exe_valid_r & ready_go_s & MEM_allow_in;
    assign mul_start_s  = (state_r == IDLE) & exe_valid_r & op_mul_s;

    // One-hot ALU; an all-zero alu_op yields zero because every term is masked off.
    logic [4:0]  shamt_s;
    logic [31:0] add_s, sub_s, slt_s, sltu_s, sra_s, alu_res_s;
    assign shamt_s = src2_s[4:0];
    assign add_s   = src1_s + src2_s;
    assign sub_s   = src1_s - src2_s;
    assign slt_s   = {31'd0, ($signed(src1_s) < $signed(src2_s))};
    assign sltu_s  = {31'd0, (src1_s < src2_s)};
    assign sra_s   = $unsigned($signed(src1_s) >>> shamt_s);

    assign alu_res_s = ({32{alu_op_s[0]}}  & add_s)
                     | ({32{alu_op_s[1]}}  & sub_s)
                     | ({32{alu_op_s[2]}}  & slt_s)
                     | ({32{alu_op_s[3]}}  & sltu_s)
                     | ({32{alu_op_s[4]}}  & (src1_s & src2_s))
                     | ({32{alu_op_s[5]}}  & ~(src1_s | src2_s))
                     | ({32{alu_op_s[6]}}  & (src1_s | src2_s))
                     | ({32{alu_op_s[7]}}  & (src1_s ^ src2_s))
                     | ({32{alu_op_s[8]}}  & (src1_s << shamt_s))
                     | ({32{alu_op_s[9]}}  & (src1_s >> shamt_s))
                     | ({32{alu_op_s[10]}} & sra_s)
                     | ({32{alu_op_s[11]}} & src2_s)
                     | ({32{alu_op_s[12]}} & acc_r);

    // Stage valid flag and issue bundle register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_valid_r <= 1'b0;
            bundle_r    <= 151'd0;
        end else if (EXE_allow_in) begin
            exe_valid_r <= ID_to_EXE_valid;
            if (ID_to_EXE_valid) begin
                bundle_r <= ID_to_EXE_bus;
            end
        end
    end

    // Multiplier state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiplier next state; DONE always drops back to IDLE so a following mul restarts cleanly.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mul_start_s) state_nxt_s = BUSY;
                else             state_nxt_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) state_nxt_s = DONE;
                else                   state_nxt_s = BUSY;
            end
            DONE: begin
                if (handoff_s) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Shift-add datapath: only the low 32 product bits are kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= '0;
            acc_r    <= 32'd0;
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
        end else if (mul_start_s) begin
            cnt_r    <= '0;
            acc_r    <= 32'd0;
            mcand_r  <= src1_s;
            mplier_r <= src2_s;
        end else if (state_r == BUSY) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
        end
    end

    assign data_valid_s = exe_valid_r & rf_w_en_s & ~rf_w_data_sel_s
                        & (~op_mul_s | (state_r == DONE));

    assign EXE_to_MEM_valid = exe_valid_r & ready_go_s;
    assign EXE_to_MEM_bus   = {rf_w_en_s, rf_w_data_sel_s, w_addr_s, alu_res_s, pc_s};
    assign EXE_BY_bus       = {w_addr_s, alu_res_s, data_valid_s, exe_valid_r & rf_w_en_s};

    assign data_sram_en    = exe_valid_r & ram_en_s & MEM_allow_in;
    assign data_sram_we    = {4{ram_we_s & data_sram_en}};
    assign data_sram_addr  = alu_res_s;
    assign data_sram_wdata = ram_wdata_s;
endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU ops, iterative mul, back-pressure,
// async reset mid-multiply and data-RAM request timing.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ID_to_EXE_valid;
    logic [150:0] ID_to_EXE_bus;
    logic         EXE_allow_in;
    logic         MEM_allow_in;
    logic         EXE_to_MEM_valid;
    logic [70:0]  EXE_to_MEM_bus;
    logic [38:0]  EXE_BY_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_stage #(.MUL_STEPS(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .ID_to_EXE_valid  (ID_to_EXE_valid),
        .ID_to_EXE_bus    (ID_to_EXE_bus),
        .EXE_allow_in     (EXE_allow_in),
        .MEM_allow_in     (MEM_allow_in),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .EXE_to_MEM_bus   (EXE_to_MEM_bus),
        .EXE_BY_bus       (EXE_BY_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    logic [31:0] mem_result;
    logic [31:0] mem_pc;
    logic        by_dv;
    logic        by_wen;
    logic [4:0]  by_waddr;
    assign mem_result = EXE_to_MEM_bus[63:32];
    assign mem_pc     = EXE_to_MEM_bus[31:0];
    assign by_dv      = EXE_BY_bus[1];
    assign by_wen     = EXE_BY_bus[0];
    assign by_waddr   = EXE_BY_bus[38:34];

    localparam logic [12:0] OP_ADD = 13'h0001;
    localparam logic [12:0] OP_SUB = 13'h0002;
    localparam logic [12:0] OP_MUL = 13'h1000;

    localparam logic [12:0] V_OP  [13] = '{13'h0002, 13'h0004, 13'h0008, 13'h0010, 13'h0020, 13'h0040,
                                           13'h0080, 13'h0100, 13'h0200, 13'h0400, 13'h0800, 13'h0000, 13'h0001};
    localparam logic [31:0] V_S1  [13] = '{32'd3, 32'd1, 32'd1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12340000,
                                           32'hFFFF0000, 32'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd5, 32'h7FFFFFFF};
    localparam logic [31:0] V_S2  [13] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF00FF00, 32'h0F0F0F00, 32'h00005678,
                                           32'h0F0F0F0F, 32'hFFFFFFE4, 32'd4, 32'd4, 32'hABCD0000, 32'd7, 32'd1};
    localparam logic [31:0] V_EXP [13] = '{32'hFFFFFFFE, 32'd0, 32'd1, 32'hF000F000, 32'h0000000F, 32'h12345678,
                                           32'hF0F00F0F, 32'h00000010, 32'h08000000, 32'hF8000000, 32'hABCD0000, 32'd0, 32'h80000000};

    function automatic logic [150:0] mk(input logic wen, input logic sel, input logic we, input logic en,
                                        input logic [31:0] wdata, input logic [4:0] wa, input logic [12:0] op,
                                        input logic [31:0] s2, input logic [31:0] s1, input logic [31:0] pc);
        return {wen, sel, 1'b0, we, en, wdata, wa, op, s2, s1, pc};
    endfunction

    // Present one bundle for a single edge; returns #1 after the following negedge.
    task automatic issue(input logic [150:0] b);
        @(negedge clk);
        ID_to_EXE_valid = 1'b1;
        ID_to_EXE_bus   = b;
        @(posedge clk);
        @(negedge clk);
        ID_to_EXE_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ID_to_EXE_valid = 1'b0; ID_to_EXE_bus = '0; MEM_allow_in = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (EXE_allow_in !== 1'b1) begin n_fail++; $display("FAIL reset_allow_in: got %b expected 1", EXE_allow_in); end
        n_checks++; if (EXE_to_MEM_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b expected 0", EXE_to_MEM_valid); end
        n_checks++; if (EXE_to_MEM_bus !== 71'd0) begin n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", EXE_to_MEM_bus); end
        n_checks++; if (EXE_BY_bus !== 39'd0) begin n_fail++; $display("FAIL reset_by_bus: got %h expected 0", EXE_BY_bus); end
        n_checks++; if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== 69'd0) begin
            n_fail++; $display("FAIL reset_sram: got en=%b we=%h addr=%h wdata=%h expected all 0", data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd3, OP_ADD, 32'hFFFFFFFF, 32'd5, 32'h00001000));
        n_checks++; if (EXE_to_MEM_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", EXE_to_MEM_valid); end
        n_checks++; if (mem_result !== 32'd4) begin n_fail++; $display("FAIL add_result: got %h expected 4", mem_result); end
        n_checks++; if (mem_pc !== 32'h00001000) begin n_fail++; $display("FAIL add_pc: got %h expected 1000", mem_pc); end
        n_checks++; if ({by_waddr, by_dv, by_wen} !== {5'd3, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL add_bypass: got waddr=%0d dv=%b wen=%b expected 3 1 1", by_waddr, by_dv, by_wen);
        end
        n_checks++; if (EXE_allow_in !== 1'b1) begin n_fail++; $display("FAIL add_allow_in: got %b expected 1", EXE_allow_in); end
        @(negedge clk); #1;
        n_checks++; if (EXE_to_MEM_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_alu_ops();
        for (int i = 0; i < 13; i++) begin
            issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'(i), V_OP[i], V_S2[i], V_S1[i], 32'h00002000));
            n_checks++;
            if (mem_result !== V_EXP[i] || EXE_to_MEM_valid !== 1'b1) begin
                n_fail++; $display("FAIL alu_vec%0d: got result=%h valid=%b expected result=%h valid=1", i, mem_result, EXE_to_MEM_valid, V_EXP[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int bad = 0;
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd7, OP_MUL, 32'd6, 32'd7, 32'h00003000));
        for (int i = 1; i <= 33; i++) begin
            if (by_dv !== 1'b0 || EXE_allow_in !== 1'b0 || EXE_to_MEM_valid !== 1'b0) bad++;
            @(negedge clk); #1;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mul_busy_window: got %0d bad cycles expected 0", bad); end
        n_checks++; if (EXE_to_MEM_valid !== 1'b1 || by_dv !== 1'b1) begin
            n_fail++; $display("FAIL mul_done_valid: got valid=%b dv=%b expected 1 1", EXE_to_MEM_valid, by_dv);
        end
        n_checks++; if (mem_result !== 32'd42) begin n_fail++; $display("FAIL mul_result: got %h expected 2a", mem_result); end
        n_checks++; if (EXE_allow_in !== 1'b1) begin n_fail++; $display("FAIL mul_done_allow: got %b expected 1", EXE_allow_in); end
        @(negedge clk); #1;
        n_checks++; if (EXE_to_MEM_valid !== 1'b0) begin n_fail++; $display("FAIL mul_handoff: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_mul_stall();
        int bad = 0;
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd9, OP_MUL, 32'd2, 32'hFFFFFFFF, 32'h00004000));
        MEM_allow_in = 1'b0;
        repeat (33) begin @(negedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            if (EXE_to_MEM_valid !== 1'b1 || mem_result !== 32'hFFFFFFFE || EXE_allow_in !== 1'b0 || by_dv !== 1'b1) bad++;
            @(negedge clk); #1;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mul_stall_hold: got %0d unstable cycles expected 0", bad); end
        MEM_allow_in = 1'b1; #1;
        n_checks++; if (EXE_allow_in !== 1'b1 || mem_result !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL mul_stall_release: got allow=%b result=%h expected 1 fffffffe", EXE_allow_in, mem_result);
        end
        @(negedge clk); #1;
        n_checks++; if (EXE_to_MEM_valid !== 1'b0) begin n_fail++; $display("FAIL mul_stall_handoff: got %b expected 0", EXE_to_MEM_valid); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        @(negedge clk);
        ID_to_EXE_valid = 1'b1;
        ID_to_EXE_bus   = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd1, OP_ADD, 32'd20, 32'd10, 32'h00005000);
        @(negedge clk);
        ID_to_EXE_bus   = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd2, OP_SUB, 32'd1, 32'd10, 32'h00005004);
        #1;
        n_checks++; if (mem_result !== 32'd30 || EXE_allow_in !== 1'b1) begin
            n_fail++; $display("FAIL b2b_alu_first: got result=%h allow=%b expected 1e 1", mem_result, EXE_allow_in);
        end
        @(negedge clk);
        ID_to_EXE_valid = 1'b0; #1;
        n_checks++; if (mem_result !== 32'd9 || EXE_to_MEM_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_alu_second: got result=%h valid=%b expected 9 1", mem_result, EXE_to_MEM_valid);
        end
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd4, OP_MUL, 32'd4, 32'd3, 32'h00005008));
        repeat (33) begin @(negedge clk); #1; end
        n_checks++; if (mem_result !== 32'd12 || EXE_to_MEM_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_mul_first: got result=%h valid=%b expected c 1", mem_result, EXE_to_MEM_valid);
        end
        ID_to_EXE_valid = 1'b1;
        ID_to_EXE_bus   = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd6, OP_MUL, 32'd5, 32'd5, 32'h0000500C);
        @(negedge clk);
        ID_to_EXE_valid = 1'b0; #1;
        for (int i = 1; i <= 33; i++) begin
            if (by_dv !== 1'b0 || EXE_to_MEM_valid !== 1'b0) bad++;
            @(negedge clk); #1;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_mul_restart: got %0d early-valid cycles expected 0", bad); end
        n_checks++; if (mem_result !== 32'd25 || EXE_to_MEM_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_mul_second: got result=%h valid=%b expected 19 1", mem_result, EXE_to_MEM_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int bad = 0;
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd8, OP_MUL, 32'd6, 32'd7, 32'h00006000));
        repeat (11) begin @(negedge clk); #1; end
        n_checks++; if (EXE_allow_in !== 1'b0) begin n_fail++; $display("FAIL rstmul_busy: got allow=%b expected 0", EXE_allow_in); end
        reset = 1'b1; #1;
        n_checks++; if (EXE_allow_in !== 1'b1 || EXE_to_MEM_valid !== 1'b0 || EXE_BY_bus !== 39'd0 || EXE_to_MEM_bus !== 71'd0) begin
            n_fail++; $display("FAIL rstmul_clear: got allow=%b valid=%b by=%h mem=%h expected 1 0 0 0", EXE_allow_in, EXE_to_MEM_valid, EXE_BY_bus, EXE_to_MEM_bus);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (EXE_to_MEM_valid !== 1'b0 || by_dv !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmul_no_partial: got %0d valid cycles expected 0", bad); end
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5'd10, OP_ADD, 32'd20, 32'd10, 32'h00006004));
        n_checks++; if (mem_result !== 32'd30 || EXE_to_MEM_valid !== 1'b1 || by_dv !== 1'b1) begin
            n_fail++; $display("FAIL rstmul_add_after: got result=%h valid=%b dv=%b expected 1e 1 1", mem_result, EXE_to_MEM_valid, by_dv);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        int bad = 0;
        MEM_allow_in = 1'b0;
        issue(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd0, OP_ADD, 32'd8, 32'h00000100, 32'h00007000));
        n_checks++; if (EXE_to_MEM_valid !== 1'b1 || EXE_allow_in !== 1'b0 || data_sram_addr !== 32'h108) begin
            n_fail++; $display("FAIL st_stalled: got valid=%b allow=%b addr=%h expected 1 0 108", EXE_to_MEM_valid, EXE_allow_in, data_sram_addr);
        end
        for (int i = 0; i < 3; i++) begin
            if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0) bad++;
            @(negedge clk); #1;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL st_en_held_low: got %0d cycles with request expected 0", bad); end
        MEM_allow_in = 1'b1; #1;
        n_checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'hF || data_sram_addr !== 32'h108 || data_sram_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL st_request: got en=%b we=%h addr=%h wdata=%h expected 1 f 108 deadbeef", data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
        end
        n_checks++; if (by_wen !== 1'b0 || by_dv !== 1'b0) begin n_fail++; $display("FAIL st_bypass: got wen=%b dv=%b expected 0 0", by_wen, by_dv); end
        @(negedge clk); #1;
        n_checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0) begin
            n_fail++; $display("FAIL st_single: got en=%b we=%h expected 0 0", data_sram_en, data_sram_we);
        end
    endtask

    task automatic test_load();
        issue(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 5'd12, OP_ADD, 32'd4, 32'h00000200, 32'h00008000));
        n_checks++; if (by_dv !== 1'b0 || by_wen !== 1'b1) begin n_fail++; $display("FAIL ld_bypass: got dv=%b wen=%b expected 0 1", by_dv, by_wen); end
        n_checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'h0 || data_sram_addr !== 32'h204) begin
            n_fail++; $display("FAIL ld_request: got en=%b we=%h addr=%h expected 1 0 204", data_sram_en, data_sram_we, data_sram_addr);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_mul();
        test_mul_stall();
        test_back_to_back();
        test_reset_mid_mul();
        test_store();
        test_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
